seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a multi-digit seven-segment display. It shares one registered hex-to-segment decoder across `DIGITS` common-anode digits. It holds a tear-free display value, drives the active digit's nibble into the decoder, and strobes one active-low digit enable at a time, with a dead-time between digits to suppress ghosting. It sits between the processor's output register and the display decoder.

---
 rtl/seg_scan_pkg.sv | 16 +
 rtl/seg_scan_ctrl_scan_timer.sv | 79 +++++++
 rtl/seg_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and widths for the seven-segment scan controller.
package seg_scan_pkg;

    // One hex digit per display position.
    localparam int NIBBLE_W = 4;

    // Width of the downstream decoder's datain bus.
    localparam int DATAIN_W = 8;

    // Each digit slot is a dead-time followed by the lit period.
    typedef enum logic {
        PH_BLANK  = 1'b0,
        PH_ACTIVE = 1'b1
    } phase_e;

endpackage

// File: rtl/seg_scan_ctrl_scan_timer.sv
// Slot timer: counts cycles inside a digit slot, steps the digit index at the
// end of each slot and tracks the BLANK/ACTIVE phase of the current slot.
// Both the current and the next-cycle phase/index are exported so the top
// level can register outputs that line up exactly with the counter.
module scan_timer
    import seg_scan_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16,
    localparam int CNT_W       = $clog2(PRESCALE),
    localparam int IDX_W       = $clog2(DIGITS)
) (
    input  logic             clk,
    input  logic             rst,
    output phase_e           phase_o,
    output logic [IDX_W-1:0] idx_o,
    output phase_e           phase_nxt_o,
    output logic [IDX_W-1:0] idx_nxt_o,
    output logic             slot_start_o,
    output logic             frame_wrap_o
);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    phase_e           phase_q, phase_d;
    logic             slot_end;

    assign slot_end = (cnt_q == CNT_LAST);

    // Slot counter and digit index; both wrap explicitly at their last value
    // because neither PRESCALE nor DIGITS needs to be a power of two.
    always_comb begin
        cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Phase next-state: BLANK hands over to ACTIVE after the dead-time, and
    // ACTIVE returns to BLANK when the slot ends.
    always_comb begin
        // NOTE: every always_comb output is assigned a default first so no
        // path through the block can leave it unassigned and infer a latch.
        phase_d = phase_q;
        case (phase_q)
            PH_BLANK:  if (cnt_q == BLANK_LAST) phase_d = PH_ACTIVE;
            PH_ACTIVE: if (slot_end)            phase_d = PH_BLANK;
        endcase
    end

    // Timer state registers; reset parks the scan at digit 0, first BLANK cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            phase_q <= PH_BLANK;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
        end
    end

    assign phase_o      = phase_q;
    assign idx_o        = idx_q;
    assign phase_nxt_o  = phase_d;
    assign idx_nxt_o    = idx_d;
    assign slot_start_o = (cnt_q == '0);
    assign frame_wrap_o = slot_end && (idx_q == IDX_LAST);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Holds a pending value written by the processor and a display value that only
// changes at the start of a frame, so a frame never mixes old and new digits.
// Feeds one nibble at a time to a shared registered decoder and strobes one
// active-low digit enable per slot, with a dead-time at the start of each slot.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [NIBBLE_W*DIGITS-1:0] value,
    input  logic                       lz_blank,
    output logic [DATAIN_W-1:0]        digit_data,
    output logic [DIGITS-1:0]          digit_en_n,
    output logic                       frame_tick
);

    localparam int VAL_W = NIBBLE_W * DIGITS;
    localparam int IDX_W = $clog2(DIGITS);

    // Timer interface
    phase_e           phase;
    phase_e           phase_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic             slot_start;
    logic             frame_wrap;

    // Value registers
    logic [VAL_W-1:0] pending_q, pending_d;
    logic [VAL_W-1:0] disp_q, disp_d;
    logic             capture;

    // Datapath
    logic [NIBBLE_W-1:0] nibble;
    logic [DIGITS-1:0]   suppress;
    logic                upper_zero;

    // Output registers
    logic [DATAIN_W-1:0] digit_data_q, digit_data_d;
    logic [DIGITS-1:0]   digit_en_n_q, digit_en_n_d;
    logic                frame_tick_q;

    scan_timer #(
        .DIGITS       (DIGITS),
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_scan_timer (
        .clk          (clk),
        .rst          (rst),
        .phase_o      (phase),
        .idx_o        (idx),
        .phase_nxt_o  (phase_nxt),
        .idx_nxt_o    (idx_nxt),
        .slot_start_o (slot_start),
        .frame_wrap_o (frame_wrap)
    );

    // The display value is refreshed only on the first BLANK cycle of digit 0.
    assign capture = slot_start && (phase == PH_BLANK) && (idx == '0);

    // Pending takes every load; disp takes pending at frame start, or the
    // incoming value directly when a load lands on that very cycle.
    always_comb begin
        pending_d = pending_q;
        if (load) begin
            pending_d = value;
        end
        disp_d = disp_q;
        if (capture) begin
            disp_d = load ? value : pending_q;
        end
    end

    // Select the current digit's nibble from the value disp is about to hold,
    // so digit 0 of a fresh frame already shows the newly captured value.
    always_comb begin
        nibble = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nibble = disp_d[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    // Leading-zero suppression: walk down from the most significant digit;
    // a digit is dark while it and everything above it is zero. Digit 0 is
    // always lit so a value of zero still shows a single '0'.
    always_comb begin
        suppress   = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            upper_zero  = upper_zero & (disp_q[i*NIBBLE_W +: NIBBLE_W] == '0);
            suppress[i] = lz_blank & upper_zero;
        end
    end

    // Next output values. Enables are computed from the timer's next-cycle
    // phase and index so the registered enable tracks the counter exactly:
    // it falls when the count reaches the end of the dead-time and rises
    // when the next slot begins. digit_data is reloaded on the first BLANK
    // cycle, giving the decoder's register stage time to settle before the
    // enable falls.
    always_comb begin
        digit_data_d = digit_data_q;
        if (slot_start) begin
            digit_data_d = {{(DATAIN_W - NIBBLE_W){1'b0}}, nibble};
        end
        digit_en_n_d = '1;
        if (phase_nxt == PH_ACTIVE) begin
            for (int i = 0; i < DIGITS; i++) begin
                if ((idx_nxt == IDX_W'(i)) && !suppress[i]) begin
                    digit_en_n_d[i] = 1'b0;
                end
            end
        end
    end

    // Value and output registers; all outputs come straight from flops so
    // the display pins never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q    <= '0;
            disp_q       <= '0;
            digit_data_q <= '0;
            digit_en_n_q <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            disp_q       <= disp_d;
            digit_data_q <= digit_data_d;
            digit_en_n_q <= digit_en_n_d;
            frame_tick_q <= frame_wrap;
        end
    end

    assign digit_data = digit_data_q;
    assign digit_en_n = digit_en_n_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.
// The reference model works from the absolute cycle number since reset release:
// slot position and digit index are plain division/modulo of that number.
module tb_seg_scan_ctrl;

    localparam int DIGITS       = 4;
    localparam int PRESCALE     = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int FRAME        = DIGITS * PRESCALE;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic        lz_blank;
    logic [7:0]  digit_data;
    logic [3:0]  digit_en_n;
    logic        frame_tick;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state: cycle number and expected outputs for that cycle.
    int unsigned t;
    logic [15:0] m_pend;
    logic [15:0] m_disp;
    logic [7:0]  m_dd;
    logic [3:0]  m_en;
    logic        m_ft;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .DIGITS       (DIGITS),
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .lz_blank   (lz_blank),
        .digit_data (digit_data),
        .digit_en_n (digit_en_n),
        .frame_tick (frame_tick)
    );

    // Digit i is dark when lz is on, i >= 1 and digits i and above are zero.
    function automatic bit lz_dark(logic [15:0] d, int i, logic lz);
        logic [15:0] upper;
        upper = d >> (4 * i);
        return lz && (i >= 1) && (upper == 16'h0000);
    endfunction

    task automatic model_reset();
        t      = 0;
        m_pend = 16'h0000;
        m_disp = 16'h0000;
        m_dd   = 8'h00;
        m_en   = 4'b1111;
        m_ft   = 1'b0;
    endtask

    // Drive inputs for the current cycle, advance the model by one cycle and
    // move to the middle of the next cycle (negedge) for sampling.
    task automatic advance(input logic ld, input logic [15:0] val, input logic lz);
        int unsigned c, i, c2, i2;
        logic [15:0] nd;
        logic [3:0]  one;
        load     = ld;
        value    = val;
        lz_blank = lz;
        c  = t % PRESCALE;
        i  = (t / PRESCALE) % DIGITS;
        nd = m_disp;
        if (c == 0 && i == 0) nd = ld ? val : m_pend;
        if (ld) m_pend = val;
        if (c == 0) m_dd = {4'h0, 4'((nd >> (4 * i)) & 16'h000F)};
        m_disp = nd;
        t  = t + 1;
        c2 = t % PRESCALE;
        i2 = (t / PRESCALE) % DIGITS;
        m_ft = (t % FRAME) == 0;
        one  = 4'b0001;
        m_en = (c2 >= BLANK_CYCLES && !lz_dark(m_disp, int'(i2), lz)) ? ~(one << i2) : 4'b1111;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        load     = 1'b0;
        value    = 16'h0000;
        lz_blank = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (digit_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_digit_data: got %h want 00", digit_data);
        end
        tests_run++;
        if (digit_en_n !== 4'b1111) begin
            tests_failed++;
            $display("FAIL reset_digit_en_n: got %b want 1111", digit_en_n);
        end
        tests_run++;
        if (frame_tick !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_frame_tick: got %b want 0", frame_tick);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset_scan();
        int first_tick = -1;
        for (int n = 0; n < 2 * FRAME; n++) begin
            tests_run++;
            if ({digit_data, digit_en_n, frame_tick} !== {m_dd, m_en, m_ft}) begin
                tests_failed++;
                $display("FAIL reset_scan t=%0d: dd/en/ft got %h/%b/%b want %h/%b/%b",
                         t, digit_data, digit_en_n, frame_tick, m_dd, m_en, m_ft);
            end
            if (frame_tick === 1'b1 && first_tick < 0) first_tick = int'(t);
            advance(1'b0, 16'h0000, 1'b0);
        end
        tests_run++;
        if (first_tick != 32) begin
            tests_failed++;
            $display("FAIL first_frame_tick: got cycle %0d want 32", first_tick);
        end
    endtask

    task automatic test_load_wrap();
        logic [7:0] exp_seq [4] = '{8'h0F, 8'h03, 8'h0A, 8'h01};
        logic [7:0] dd_before;
        for (int n = 0; n < FRAME && (t % FRAME) != 10; n++) advance(1'b0, 16'h0000, 1'b0);
        dd_before = m_dd;
        advance(1'b1, 16'h1A3F, 1'b0);
        // Mid-frame load must not reach the display before the wrap.
        for (int n = 0; n < FRAME && (t % FRAME) != 1; n++) begin
            tests_run++;
            if (digit_data !== dd_before || {digit_en_n, frame_tick} !== {m_en, m_ft}) begin
                tests_failed++;
                $display("FAIL load_hold t=%0d: dd/en/ft got %h/%b/%b want %h/%b/%b",
                         t, digit_data, digit_en_n, frame_tick, dd_before, m_en, m_ft);
            end
            advance(1'b0, 16'h0000, 1'b0);
        end
        for (int n = 0; n < FRAME; n++) begin
            if ((t % PRESCALE) == 1) begin
                tests_run++;
                if (digit_data !== exp_seq[(t % FRAME) / PRESCALE]) begin
                    tests_failed++;
                    $display("FAIL load_sequence t=%0d: got %h want %h",
                             t, digit_data, exp_seq[(t % FRAME) / PRESCALE]);
                end
            end
            tests_run++;
            if ({digit_data, digit_en_n, frame_tick} !== {m_dd, m_en, m_ft}) begin
                tests_failed++;
                $display("FAIL load_frame t=%0d: dd/en/ft got %h/%b/%b want %h/%b/%b",
                         t, digit_data, digit_en_n, frame_tick, m_dd, m_en, m_ft);
            end
            advance(1'b0, 16'h0000, 1'b0);
        end
    endtask

    task automatic test_bypass();
        for (int n = 0; n < FRAME && (t % FRAME) != 5; n++) advance(1'b0, 16'h0000, 1'b0);
        advance(1'b1, 16'h1234, 1'b0);
        for (int n = 0; n < FRAME && (t % FRAME) != 0; n++) begin
            tests_run++;
            if ({digit_data, digit_en_n, frame_tick} !== {m_dd, m_en, m_ft}) begin
                tests_failed++;
                $display("FAIL bypass_pre t=%0d: dd/en/ft got %h/%b/%b want %h/%b/%b",
                         t, digit_data, digit_en_n, frame_tick, m_dd, m_en, m_ft);
            end
            advance(1'b0, 16'h0000, 1'b0);
        end
        tests_run++;
        if (frame_tick !== 1'b1) begin
            tests_failed++;
            $display("FAIL bypass_wrap_tick t=%0d: got %b want 1", t, frame_tick);
        end
        advance(1'b1, 16'hBEEF, 1'b0);
        tests_run++;
        if (digit_data !== 8'h0F) begin
            tests_failed++;
            $display("FAIL bypass_digit0 t=%0d: got %h want 0f", t, digit_data);
        end
        for (int n = 0; n < FRAME; n++) begin
            tests_run++;
            if ({digit_data, digit_en_n, frame_tick} !== {m_dd, m_en, m_ft}) begin
                tests_failed++;
                $display("FAIL bypass_frame t=%0d: dd/en/ft got %h/%b/%b want %h/%b/%b",
                         t, digit_data, digit_en_n, frame_tick, m_dd, m_en, m_ft);
            end
            advance(1'b0, 16'h0000, 1'b0);
        end
    endtask

    // Load a value mid-frame with suppression on, skip to the frame where it
    // is displayed, and check every ACTIVE cycle against a fixed enable table.
    task automatic lz_case(input logic [15:0] val, input logic [3:0] exp_en [4], input string tag);
        for (int n = 0; n < FRAME && (t % FRAME) != 6; n++) advance(1'b0, 16'h0000, 1'b1);
        advance(1'b1, val, 1'b1);
        for (int n = 0; n < FRAME && (t % FRAME) != 1; n++) advance(1'b0, 16'h0000, 1'b1);
        for (int n = 0; n < FRAME; n++) begin
            if ((t % PRESCALE) >= BLANK_CYCLES) begin
                tests_run++;
                if (digit_en_n !== exp_en[(t % FRAME) / PRESCALE]) begin
                    tests_failed++;
                    $display("FAIL %s t=%0d: en got %b want %b",
                             tag, t, digit_en_n, exp_en[(t % FRAME) / PRESCALE]);
                end
            end
            tests_run++;
            if ({digit_data, digit_en_n, frame_tick} !== {m_dd, m_en, m_ft}) begin
                tests_failed++;
                $display("FAIL %s_model t=%0d: dd/en/ft got %h/%b/%b want %h/%b/%b",
                         tag, t, digit_data, digit_en_n, frame_tick, m_dd, m_en, m_ft);
            end
            advance(1'b0, 16'h0000, 1'b1);
        end
    endtask

    task automatic test_lz_blank();
        logic [3:0] en_0050 [4] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
        logic [3:0] en_0000 [4] = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
        lz_case(16'h0050, en_0050, "lz_0050");
        lz_case(16'h0000, en_0000, "lz_0000");
    endtask

    task automatic test_random();
        logic [15:0] masks [5] = '{16'h0000, 16'h000F, 16'h00FF, 16'h0FFF, 16'hFFFF};
        logic        lz = 1'b0;
        logic        ld;
        logic [15:0] v;
        for (int n = 0; n < 640; n++) begin
            tests_run++;
            if ({digit_data, digit_en_n, frame_tick} !== {m_dd, m_en, m_ft}) begin
                tests_failed++;
                $display("FAIL random t=%0d: dd/en/ft got %h/%b/%b want %h/%b/%b",
                         t, digit_data, digit_en_n, frame_tick, m_dd, m_en, m_ft);
            end
            if ((n % 50) == 0) lz = 1'($urandom_range(1, 0));
            ld = ($urandom_range(5, 0) == 0);
            v  = 16'($urandom) & masks[$urandom_range(4, 0)];
            advance(ld, v, lz);
        end
    endtask

    task automatic test_reset_mid();
        // Leave a non-zero value pending so a missed pending reset is visible.
        for (int n = 0; n < FRAME && (t % FRAME) != 3; n++) advance(1'b0, 16'h0000, 1'b0);
        advance(1'b1, 16'h7777, 1'b0);
        for (int n = 0; n < FRAME && (t % FRAME) != 20; n++) advance(1'b0, 16'h0000, 1'b0);
        tests_run++;
        if (digit_en_n !== 4'b1011) begin
            tests_failed++;
            $display("FAIL reset_mid_pre t=%0d: en got %b want 1011", t, digit_en_n);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({digit_data, digit_en_n, frame_tick} !== {8'h00, 4'b1111, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_mid_async: dd/en/ft got %h/%b/%b want 00/1111/0",
                     digit_data, digit_en_n, frame_tick);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < FRAME + 8; n++) begin
            if (n == 2) begin
                tests_run++;
                if ({digit_data, digit_en_n} !== {8'h00, 4'b1110}) begin
                    tests_failed++;
                    $display("FAIL reset_mid_restart t=%0d: dd/en got %h/%b want 00/1110",
                             t, digit_data, digit_en_n);
                end
            end
            tests_run++;
            if ({digit_data, digit_en_n, frame_tick} !== {m_dd, m_en, m_ft}) begin
                tests_failed++;
                $display("FAIL reset_mid_model t=%0d: dd/en/ft got %h/%b/%b want %h/%b/%b",
                         t, digit_data, digit_en_n, frame_tick, m_dd, m_en, m_ft);
            end
            advance(1'b0, 16'h0000, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_reset_scan();
        test_load_wrap();
        test_bypass();
        test_lz_blank();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
